// File: rtl/mc_ctrl_fsm.sv
`default_nettype none
// ==========================================================================
// mc_ctrl_fsm : multi-cycle MIPS control sequencer with shared memory port,
//               bus watchdog and retired-instruction counter
// Revision    : 1.0
// ==========================================================================
module mc_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_we,
  output logic        mdr_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        alu_srca,
  output logic [1:0]  alu_srcb,
  output logic [2:0]  alu_op,
  output logic        ext_op,
  output logic        reg_we,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wd_sel,
  output logic        illegal,
  output logic        bus_err,
  output logic [31:0] instr_cnt
);

  localparam logic [5:0] C_OP_RTYPE = 6'b000000;
  localparam logic [5:0] C_OP_LW    = 6'b100011;
  localparam logic [5:0] C_OP_SW    = 6'b101011;
  localparam logic [5:0] C_OP_ORI   = 6'b001101;
  localparam logic [5:0] C_OP_LUI   = 6'b001111;
  localparam logic [5:0] C_OP_BEQ   = 6'b000100;
  localparam logic [5:0] C_OP_J     = 6'b000010;
  localparam logic [5:0] C_OP_JAL   = 6'b000011;
  localparam logic [5:0] C_FN_ADDU  = 6'b100001;
  localparam logic [5:0] C_FN_SUBU  = 6'b100011;
  localparam logic [5:0] C_FN_JR    = 6'b001000;
  localparam logic [5:0] C_FN_NOP   = 6'b000000;

  localparam logic [2:0] C_ALU_ADD  = 3'd0;
  localparam logic [2:0] C_ALU_SUB  = 3'd1;
  localparam logic [2:0] C_ALU_OR   = 3'd2;
  localparam logic [2:0] C_ALU_LUI  = 3'd3;

  localparam logic [15:0] C_WAIT_LAST = 16'(MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_WB_R     = 4'd3,
    S_EXEC_I   = 4'd4,
    S_WB_I     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JR       = 4'd12,
    S_HALT     = 4'd13
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        bus_err_q, bus_err_d;
  logic [31:0] instr_cnt_q, instr_cnt_d;

  logic w_waiting;
  logic w_expire;

  // Watchdog only runs in states that hold mem_req; a ready in the expiry cycle wins.
  assign w_waiting = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign w_expire  = w_waiting && !mem_ready && (wait_cnt_q == C_WAIT_LAST);

  always_comb begin
    state_d  = state_q;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    iord     = 1'b0;
    ir_we    = 1'b0;
    mdr_we   = 1'b0;
    pc_we    = 1'b0;
    pc_src   = 2'd0;
    alu_srca = 1'b0;
    alu_srcb = 2'd0;
    alu_op   = C_ALU_ADD;
    ext_op   = 1'b0;
    reg_we   = 1'b0;
    reg_dst  = 2'd0;
    wd_sel   = 2'd0;
    illegal  = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        alu_srcb = 2'd1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end else if (w_expire) begin
          state_d = S_HALT;
        end
      end
      S_DECODE: begin
        // Branch target is computed speculatively into ALUOut here.
        alu_srcb = 2'd3;
        ext_op   = 1'b1;
        case (opcode)
          C_OP_RTYPE: begin
            case (funct)
              C_FN_ADDU, C_FN_SUBU: state_d = S_EXEC_R;
              C_FN_JR:              state_d = S_JR;
              C_FN_NOP:             state_d = S_FETCH;
              default: begin
                illegal = 1'b1;
                state_d = S_FETCH;
              end
            endcase
          end
          C_OP_LW, C_OP_SW:   state_d = S_MEM_ADDR;
          C_OP_ORI, C_OP_LUI: state_d = S_EXEC_I;
          C_OP_BEQ:           state_d = S_BRANCH;
          C_OP_J, C_OP_JAL:   state_d = S_JUMP;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_srca = 1'b1;
        alu_op   = (funct == C_FN_SUBU) ? C_ALU_SUB : C_ALU_ADD;
        state_d  = S_WB_R;
      end
      S_WB_R: begin
        reg_we  = 1'b1;
        reg_dst = 2'd1;
        state_d = S_FETCH;
      end
      S_EXEC_I: begin
        alu_srcb = 2'd2;
        alu_srca = (opcode == C_OP_ORI);
        alu_op   = (opcode == C_OP_ORI) ? C_ALU_OR : C_ALU_LUI;
        state_d  = S_WB_I;
      end
      S_WB_I: begin
        reg_we  = 1'b1;
        state_d = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_srca = 1'b1;
        alu_srcb = 2'd2;
        ext_op   = 1'b1;
        state_d  = (opcode == C_OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          mdr_we  = 1'b1;
          state_d = S_WB_MEM;
        end else if (w_expire) begin
          state_d = S_HALT;
        end
      end
      S_WB_MEM: begin
        reg_we  = 1'b1;
        wd_sel  = 2'd1;
        state_d = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
        end else if (w_expire) begin
          state_d = S_HALT;
        end
      end
      S_BRANCH: begin
        alu_srca = 1'b1;
        alu_op   = C_ALU_SUB;
        pc_src   = 2'd1;
        pc_we    = zero;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        pc_we  = 1'b1;
        pc_src = 2'd2;
        if (opcode == C_OP_JAL) begin
          reg_we  = 1'b1;
          reg_dst = 2'd2;
          wd_sel  = 2'd2;
        end
        state_d = S_FETCH;
      end
      S_JR: begin
        pc_we   = 1'b1;
        pc_src  = 2'd3;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase

    // Strobes must not reach the datapath while reset is asserted, even mid-access.
    if (reset) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      ir_we   = 1'b0;
      mdr_we  = 1'b0;
      pc_we   = 1'b0;
      reg_we  = 1'b0;
      illegal = 1'b0;
    end
  end

  always_comb begin
    wait_cnt_d  = (w_waiting && (state_d == state_q)) ? wait_cnt_q + 16'd1 : 16'd0;
    bus_err_d   = bus_err_q | w_expire;
    instr_cnt_d = instr_cnt_q;
    if ((state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_HALT)) begin
      instr_cnt_d = instr_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      wait_cnt_q  <= 16'd0;
      bus_err_q   <= 1'b0;
      instr_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      bus_err_q   <= bus_err_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign bus_err   = bus_err_q;
  assign instr_cnt = instr_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_fsm.sv
`default_nettype none
// ==========================================================================
// tb_mc_ctrl_fsm : cycle-by-cycle trace check of mc_ctrl_fsm against an
//                  instruction-level expectation generator
// Revision       : 1.0
// ==========================================================================
module tb_mc_ctrl_fsm;

  localparam int MEM_TIMEOUT = 4;

  localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LUI = 3, K_LW = 4, K_SW = 5;
  localparam int K_BEQ = 6, K_J = 7, K_JAL = 8, K_JR = 9, K_NOP = 10, K_ILL = 11, K_ILLR = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode, funct;
  logic        zero, mem_ready;
  logic        mem_req, mem_we, iord, ir_we, mdr_we, pc_we;
  logic [1:0]  pc_src;
  logic        alu_srca;
  logic [1:0]  alu_srcb;
  logic [2:0]  alu_op;
  logic        ext_op, reg_we;
  logic [1:0]  reg_dst, wd_sel;
  logic        illegal, bus_err;
  logic [31:0] instr_cnt;

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_we(ir_we), .mdr_we(mdr_we), .pc_we(pc_we), .pc_src(pc_src),
    .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_op(alu_op), .ext_op(ext_op),
    .reg_we(reg_we), .reg_dst(reg_dst), .wd_sel(wd_sel), .illegal(illegal),
    .bus_err(bus_err), .instr_cnt(instr_cnt)
  );

  typedef struct packed {
    logic        mem_req, mem_we, iord, ir_we, mdr_we, pc_we;
    logic [1:0]  pc_src;
    logic        alu_srca;
    logic [1:0]  alu_srcb;
    logic [2:0]  alu_op;
    logic        ext_op, reg_we;
    logic [1:0]  reg_dst, wd_sel;
    logic        illegal, bus_err;
    logic [31:0] instr_cnt;
  } out_t;

  typedef struct {
    string      name;
    logic       rst;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    logic       rdy;
    logic       en_only;
    out_t       exp;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] m_cnt = 32'd0;
  logic        m_err = 1'b0;
  int          checks = 0;
  int          failures = 0;

  function automatic logic rnd();
    return 1'($urandom);
  endfunction

  function automatic out_t base_out();
    out_t o;
    o = '0;
    o.bus_err   = m_err;
    o.instr_cnt = m_cnt;
    return o;
  endfunction

  task automatic push(input string nm, input logic rst, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic rdy, input logic en_only, input out_t e);
    vec_t v;
    v.name = nm; v.rst = rst; v.op = op; v.fn = fn; v.z = z; v.rdy = rdy;
    v.en_only = en_only; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic enc(input int k, output logic [5:0] op, output logic [5:0] fn);
    fn = 6'($urandom);
    case (k)
      K_ADDU: begin op = 6'b000000; fn = 6'b100001; end
      K_SUBU: begin op = 6'b000000; fn = 6'b100011; end
      K_JR:   begin op = 6'b000000; fn = 6'b001000; end
      K_NOP:  begin op = 6'b000000; fn = 6'b000000; end
      K_ILLR: begin op = 6'b000000; fn = 6'b100000; end
      K_ORI:  op = 6'b001101;
      K_LUI:  op = 6'b001111;
      K_LW:   op = 6'b100011;
      K_SW:   op = 6'b101011;
      K_BEQ:  op = 6'b000100;
      K_J:    op = 6'b000010;
      K_JAL:  op = 6'b000011;
      default: op = 6'b111111;
    endcase
  endtask

  task automatic do_reset(input string nm, input int n);
    for (int i = 0; i < n; i++) push(nm, 1'b1, 6'($urandom), 6'($urandom), rnd(), rnd(), 1'b1, '0);
    m_cnt = 32'd0;
    m_err = 1'b0;
  endtask

  // A memory access waits `delay` cycles for ready; the watchdog trips on the
  // MEM_TIMEOUT-th consecutive not-ready cycle unless ready arrives in it.
  task automatic mem_phase(input string nm, input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input out_t w, input out_t r, input int delay, output bit to);
    to = 1'b0;
    for (int i = 0; i <= delay; i++) begin
      if (i == delay) begin
        push(nm, 1'b0, op, fn, z, 1'b1, 1'b0, r);
        return;
      end
      push(nm, 1'b0, op, fn, z, 1'b0, 1'b0, w);
      if (i == MEM_TIMEOUT - 1) begin
        m_err = 1'b1;
        to    = 1'b1;
        return;
      end
    end
  endtask

  task automatic halt_reset(input string nm);
    for (int i = 0; i < 3; i++) push({nm, "_halt"}, 1'b0, 6'($urandom), 6'($urandom), rnd(), rnd(), 1'b0, base_out());
    do_reset({nm, "_rst"}, 1 + int'($urandom_range(0, 1)));
  endtask

  task automatic gen_instr(input string nm, input int k, input logic z, input int df, input int dm);
    logic [5:0] op, fn;
    out_t w, r, o;
    bit   to;
    enc(k, op, fn);
    w = base_out(); w.mem_req = 1'b1; w.alu_srcb = 2'd1;
    r = w; r.ir_we = 1'b1; r.pc_we = 1'b1;
    mem_phase({nm, "_fetch"}, op, fn, z, w, r, df, to);
    if (to) begin halt_reset(nm); return; end
    o = base_out(); o.alu_srcb = 2'd3; o.ext_op = 1'b1; o.illegal = (k == K_ILL) || (k == K_ILLR);
    push({nm, "_decode"}, 1'b0, op, fn, z, rnd(), 1'b0, o);
    case (k)
      K_ADDU, K_SUBU: begin
        o = base_out(); o.alu_srca = 1'b1; o.alu_op = (k == K_SUBU) ? 3'd1 : 3'd0;
        push({nm, "_exec"}, 1'b0, op, fn, z, rnd(), 1'b0, o);
        o = base_out(); o.reg_we = 1'b1; o.reg_dst = 2'd1;
        push({nm, "_wb"}, 1'b0, op, fn, z, rnd(), 1'b0, o);
      end
      K_ORI, K_LUI: begin
        o = base_out(); o.alu_srcb = 2'd2; o.alu_srca = (k == K_ORI);
        o.alu_op = (k == K_ORI) ? 3'd2 : 3'd3;
        push({nm, "_exec"}, 1'b0, op, fn, z, rnd(), 1'b0, o);
        o = base_out(); o.reg_we = 1'b1;
        push({nm, "_wb"}, 1'b0, op, fn, z, rnd(), 1'b0, o);
      end
      K_LW, K_SW: begin
        o = base_out(); o.alu_srca = 1'b1; o.alu_srcb = 2'd2; o.ext_op = 1'b1;
        push({nm, "_addr"}, 1'b0, op, fn, z, rnd(), 1'b0, o);
        w = base_out(); w.mem_req = 1'b1; w.iord = 1'b1; w.mem_we = (k == K_SW);
        r = w; r.mdr_we = (k == K_LW);
        mem_phase({nm, "_mem"}, op, fn, z, w, r, dm, to);
        if (to) begin halt_reset(nm); return; end
        if (k == K_LW) begin
          o = base_out(); o.reg_we = 1'b1; o.wd_sel = 2'd1;
          push({nm, "_wb"}, 1'b0, op, fn, z, rnd(), 1'b0, o);
        end
      end
      K_BEQ: begin
        o = base_out(); o.alu_srca = 1'b1; o.alu_op = 3'd1; o.pc_src = 2'd1; o.pc_we = z;
        push({nm, "_branch"}, 1'b0, op, fn, z, rnd(), 1'b0, o);
      end
      K_J, K_JAL: begin
        o = base_out(); o.pc_we = 1'b1; o.pc_src = 2'd2;
        if (k == K_JAL) begin o.reg_we = 1'b1; o.reg_dst = 2'd2; o.wd_sel = 2'd2; end
        push({nm, "_jump"}, 1'b0, op, fn, z, rnd(), 1'b0, o);
      end
      K_JR: begin
        o = base_out(); o.pc_we = 1'b1; o.pc_src = 2'd3;
        push({nm, "_jr"}, 1'b0, op, fn, z, rnd(), 1'b0, o);
      end
      default: ;
    endcase
    m_cnt = m_cnt + 32'd1;
  endtask

  task automatic reset_mid_write();
    logic [5:0] op, fn;
    out_t o;
    enc(K_SW, op, fn);
    o = base_out(); o.mem_req = 1'b1; o.alu_srcb = 2'd1; o.ir_we = 1'b1; o.pc_we = 1'b1;
    push("rstwr_fetch", 1'b0, op, fn, 1'b0, 1'b1, 1'b0, o);
    o = base_out(); o.alu_srcb = 2'd3; o.ext_op = 1'b1;
    push("rstwr_decode", 1'b0, op, fn, 1'b0, 1'b0, 1'b0, o);
    o = base_out(); o.alu_srca = 1'b1; o.alu_srcb = 2'd2; o.ext_op = 1'b1;
    push("rstwr_addr", 1'b0, op, fn, 1'b0, 1'b0, 1'b0, o);
    o = base_out(); o.mem_req = 1'b1; o.mem_we = 1'b1; o.iord = 1'b1;
    push("rstwr_wait", 1'b0, op, fn, 1'b0, 1'b0, 1'b0, o);
    push("rstwr_reset", 1'b1, op, fn, 1'b0, 1'b1, 1'b1, '0);
    m_cnt = 32'd0;
    m_err = 1'b0;
  endtask

  initial begin
    out_t act;
    int   k;

    reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;

    do_reset("por", 3);
    gen_instr("addu", K_ADDU, 1'b0, 0, 0);
    gen_instr("lw_d3", K_LW, 1'b0, 0, 3);
    gen_instr("beq_z1", K_BEQ, 1'b1, 0, 0);
    gen_instr("beq_z0", K_BEQ, 1'b0, 0, 0);
    gen_instr("jal", K_JAL, 1'b0, 0, 0);
    gen_instr("jr", K_JR, 1'b0, 0, 0);
    gen_instr("illop", K_ILL, 1'b0, 0, 0);
    gen_instr("nop", K_NOP, 1'b0, 0, 0);
    gen_instr("fetch_d3", K_SUBU, 1'b0, 3, 0);
    gen_instr("fetch_to", K_ORI, 1'b0, 10, 0);
    gen_instr("lui", K_LUI, 1'b0, 1, 0);
    gen_instr("sw_to", K_SW, 1'b0, 0, 4);
    gen_instr("j", K_J, 1'b0, 0, 0);
    reset_mid_write();
    gen_instr("after_rst", K_ADDU, 1'b0, 0, 0);

    for (int n = 0; n < 250; n++) begin
      k = int'($urandom_range(0, 12));
      gen_instr($sformatf("rnd%0d", n), k, rnd(),
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3)),
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3)));
    end

    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      reset     = vecs[i].rst;
      opcode    = vecs[i].op;
      funct     = vecs[i].fn;
      zero      = vecs[i].z;
      mem_ready = vecs[i].rdy;
      @(negedge clk);
      act = {mem_req, mem_we, iord, ir_we, mdr_we, pc_we, pc_src, alu_srca, alu_srcb, alu_op,
             ext_op, reg_we, reg_dst, wd_sel, illegal, bus_err, instr_cnt};
      checks++;
      if (vecs[i].en_only) begin
        if ({mem_req, mem_we, ir_we, mdr_we, pc_we, reg_we, illegal} !== 7'd0) begin
          failures++;
          $display("FAIL %s vec=%0d strobes actual=%b required=0000000", vecs[i].name, i,
                   {mem_req, mem_we, ir_we, mdr_we, pc_we, reg_we, illegal});
        end
      end else if (act !== vecs[i].exp) begin
        failures++;
        $display("FAIL %s vec=%0d outputs actual=%h required=%h", vecs[i].name, i, act, vecs[i].exp);
      end
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
